// File: rtl/dmem_responder.sv
// Data-memory responder: the target end of the core's dmem_* load/store port.
// It holds a word-addressed, byte-writable RAM and services one access at a time
// with a fixed latency. stall_v_o freezes the pipeline until each access completes.
//
// Parameters:
//   words_p   - RAM depth in 32-bit words (power of two, >= 2)
//   latency_p - cycles from request acceptance to completion (>= 1)
// Ports:
//   clk_i        - clock, rising edge
//   rst_i        - asynchronous active-low reset
//   dmem_r_v_i   - read request
//   dmem_w_v_i   - write request (wins when both request inputs are high)
//   dmem_addr_i  - byte address; addr[1:0] and bits above the word index are ignored
//   dmem_data_i  - lane-aligned write data
//   dmem_wmask_i - byte write enables
//   dmem_data_o  - registered read data, held until the next completed read
//   fault_o      - out-of-range access flag, high for the DONE cycle
//                  (only when DMEM_RANGE_CHECK_EN is defined)
//   stall_v_o    - combinational: access in progress
// Optional feature macro: DMEM_RANGE_CHECK_EN.

module dmem_responder #(
    parameter int unsigned words_p   = 1024,
    parameter int unsigned latency_p = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        dmem_r_v_i,
    input  logic        dmem_w_v_i,
    input  logic [31:0] dmem_addr_i,
    input  logic [31:0] dmem_data_i,
    input  logic [3:0]  dmem_wmask_i,
    output logic [31:0] dmem_data_o,
`ifdef DMEM_RANGE_CHECK_EN
    output logic        fault_o,
`endif
    output logic        stall_v_o
);

    localparam int unsigned IDX_W = $clog2(words_p);
    localparam int unsigned CNT_W = $clog2(latency_p + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD =
        (latency_p >= 2) ? CNT_W'(latency_p - 2) : '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_r, state_nxt;
    logic [CNT_W-1:0]   cnt_r, cnt_nxt;

    logic               req_w_r;
    logic [IDX_W-1:0]   req_idx_r;
    logic [31:0]        req_data_r;
    logic [3:0]         req_mask_r;
    logic               req_oob_r;

    logic [31:0]        mem [words_p];

    logic               req_c;
    logic               in_idle_c;
    logic               oob_in_c;
    logic               eff_w_c;
    logic [IDX_W-1:0]   eff_idx_c;
    logic [31:0]        eff_data_c;
    logic [3:0]         eff_mask_c;
    logic               eff_oob_c;
    logic               complete_c;

    assign req_c     = dmem_r_v_i | dmem_w_v_i;
    assign in_idle_c = (state_r == IDLE);

`ifdef DMEM_RANGE_CHECK_EN
    localparam logic [32:0] ADDR_LIM = 33'(64'(words_p) * 64'd4);
    assign oob_in_c = ({1'b0, dmem_addr_i} >= ADDR_LIM);
`else
    // Word index bits only; the rest of the address aliases.
    logic unused_addr_c;
    assign unused_addr_c = ^dmem_addr_i;
    assign oob_in_c      = 1'b0;
`endif

    // With latency_p == 1 the completion edge is also the acceptance edge, so the
    // live request inputs stand in for the request registers while in IDLE.
    assign eff_w_c    = in_idle_c ? dmem_w_v_i               : req_w_r;
    assign eff_idx_c  = in_idle_c ? dmem_addr_i[2 +: IDX_W]  : req_idx_r;
    assign eff_data_c = in_idle_c ? dmem_data_i              : req_data_r;
    assign eff_mask_c = in_idle_c ? dmem_wmask_i             : req_mask_r;
    assign eff_oob_c  = in_idle_c ? oob_in_c                 : req_oob_r;

    assign complete_c = (state_nxt == DONE) && (state_r != DONE);

    assign stall_v_o  = (in_idle_c && req_c) || (state_r == BUSY);

    // Next-state and latency counter.
    always_comb begin
        state_nxt = state_r;
        cnt_nxt   = cnt_r;
        case (state_r)
            IDLE: begin
                if (req_c) begin
                    if (latency_p == 1) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = BUSY;
                        cnt_nxt   = CNT_LOAD;
                    end
                end
            end
            BUSY: begin
                if (cnt_r == '0) begin
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt_r - CNT_W'(1);
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register, request capture and registered outputs.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r     <= IDLE;
            cnt_r       <= '0;
            req_w_r     <= 1'b0;
            req_idx_r   <= '0;
            req_data_r  <= '0;
            req_mask_r  <= '0;
            req_oob_r   <= 1'b0;
            dmem_data_o <= '0;
        end else begin
            state_r <= state_nxt;
            cnt_r   <= cnt_nxt;
            if (in_idle_c && req_c) begin
                req_w_r    <= dmem_w_v_i;
                req_idx_r  <= dmem_addr_i[2 +: IDX_W];
                req_data_r <= dmem_data_i;
                req_mask_r <= dmem_wmask_i;
                req_oob_r  <= oob_in_c;
            end
            if (complete_c && !eff_w_c) begin
                dmem_data_o <= eff_oob_c ? 32'h0 : mem[eff_idx_c];
            end
        end
    end

`ifdef DMEM_RANGE_CHECK_EN
    // Fault flag covers exactly the DONE cycle of an out-of-range access.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            fault_o <= 1'b0;
        end else begin
            fault_o <= complete_c && eff_oob_c;
        end
    end
`endif

    // Byte-masked RAM write on the completion edge; contents are not reset.
    always_ff @(posedge clk_i) begin
        if (complete_c && eff_w_c && !eff_oob_c) begin
            for (int n = 0; n < 4; n++) begin
                if (eff_mask_c[n]) begin
                    mem[eff_idx_c][8*n +: 8] <= eff_data_c[8*n +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboarded bench for dmem_responder: a byte-level memory model predicts each
// access's DONE-cycle output; a monitor pops and compares when an access completes.

module tb_dmem_responder;

    localparam int unsigned WORDS = 1024;
    localparam int unsigned LAT   = 2;

    logic        clk;
    logic        rst_n;
    logic        r_v;
    logic        w_v;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [31:0] rdata;
    logic        stall;
`ifdef DMEM_RANGE_CHECK_EN
    logic        fault;
`endif

    dmem_responder #(
        .words_p   (WORDS),
        .latency_p (LAT)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_n),
        .dmem_r_v_i   (r_v),
        .dmem_w_v_i   (w_v),
        .dmem_addr_i  (addr),
        .dmem_data_i  (wdata),
        .dmem_wmask_i (wmask),
        .dmem_data_o  (rdata),
`ifdef DMEM_RANGE_CHECK_EN
        .fault_o      (fault),
`endif
        .stall_v_o    (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          is_rd;
        logic [31:0] exp;
        logic [31:0] care;
        bit          flt;
    } exp_t;

    exp_t        sb_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    logic [7:0]  mem_m   [WORDS][4];
    bit          known_m [WORDS][4];
    logic [31:0] last_val;
    logic [31:0] last_care;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp, input logic [31:0] care);
        n_tests++;
        if (((act ^ exp) & care) != 32'h0) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (care %h) at %0t", name, act, exp, care, $time);
        end
    endtask

    function automatic void model_reset();
        last_val  = 32'h0;
        last_care = 32'hFFFF_FFFF;
    endfunction

    // Predict the access, push the expectation, drive it and wait for DONE.
    task automatic issue(input bit r, input bit w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] m);
        exp_t e;
        int   idx;
        int   k;
        bit   oob;
        idx = int'((a >> 2) % WORDS);
        oob = 1'b0;
`ifdef DMEM_RANGE_CHECK_EN
        oob = (64'(a) >= 64'(4 * WORDS));
`endif
        if (w) begin
            if (!oob) begin
                for (int b = 0; b < 4; b++) begin
                    if (m[b]) begin
                        mem_m[idx][b]   = d[8*b +: 8];
                        known_m[idx][b] = 1'b1;
                    end
                end
            end
            e.is_rd = 1'b0;
        end else begin
            if (oob) begin
                last_val  = 32'h0;
                last_care = 32'hFFFF_FFFF;
            end else begin
                for (int b = 0; b < 4; b++) begin
                    last_val[8*b +: 8]  = mem_m[idx][b];
                    last_care[8*b +: 8] = known_m[idx][b] ? 8'hFF : 8'h00;
                end
            end
            e.is_rd = 1'b1;
        end
        e.exp  = last_val;
        e.care = last_care;
        e.flt  = oob;
        sb_q.push_back(e);

        r_v = r; w_v = w; addr = a; wdata = d; wmask = m;
        @(posedge clk);
        @(negedge clk);
        // Post-acceptance input changes must have no effect.
        r_v = 1'b0; w_v = 1'b0;
        addr = $urandom; wdata = $urandom; wmask = 4'($urandom);
        k = 0;
        forever begin
            #2;
            if (!stall) break;
            k++;
            if (k > 16) begin
                n_tests++; n_fail++;
                $display("FAIL timeout: stall still %b after %0d cycles, required 0", stall, k);
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        repeat ($urandom_range(0, 2)) @(negedge clk);
    endtask

    // Monitor: a falling stall after a high run marks the DONE cycle.
    initial begin
        int   streak;
        exp_t e;
        streak = 0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                streak = 0;
            end else if (stall) begin
                streak++;
            end else if (streak > 0) begin
                if (sb_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_done: got completion, required none pending");
                end else begin
                    e = sb_q.pop_front();
                    check("stall_len", 32'(streak), 32'(LAT), 32'hFFFF_FFFF);
                    check(e.is_rd ? "rd_data" : "hold_data", rdata, e.exp, e.care);
`ifdef DMEM_RANGE_CHECK_EN
                    check("fault_done", 32'(fault), 32'(e.flt), 32'h1);
`endif
                end
                streak = 0;
            end else begin
`ifdef DMEM_RANGE_CHECK_EN
                check("fault_idle", 32'(fault), 32'h0, 32'h1);
`endif
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          kind;
        logic [31:0] a;

        for (int i = 0; i < int'(WORDS); i++) begin
            for (int b = 0; b < 4; b++) known_m[i][b] = 1'b0;
        end
        model_reset();
        rst_n = 1'b0;
        r_v = 1'b0; w_v = 1'b0; addr = '0; wdata = '0; wmask = '0;

        // Reset state.
        repeat (3) @(negedge clk);
        #1;
        check("rst_data", rdata, 32'h0, 32'hFFFF_FFFF);
        check("rst_stall_idle", 32'(stall), 32'h0, 32'h1);
        r_v = 1'b1;
        #1;
        check("rst_stall_req", 32'(stall), 32'h1, 32'h1);
        r_v = 1'b0;
`ifdef DMEM_RANGE_CHECK_EN
        check("rst_fault", 32'(fault), 32'h0, 32'h1);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // First read after reset: RAM contents unknown, timing checked.
        issue(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);

        // Masked write merge.
        issue(1'b0, 1'b1, 32'h40, 32'hAABB_CCDD, 4'b1111);
        issue(1'b0, 1'b1, 32'h40, 32'h1122_3344, 4'b0101);
        issue(1'b1, 1'b0, 32'h40, 32'h0, 4'h0);

        // Both request inputs high act as a write.
        issue(1'b1, 1'b1, 32'h8, 32'h1234_5678, 4'b1111);
        issue(1'b1, 1'b0, 32'h8, 32'h0, 4'h0);

        // Address 0x1000: aliases to word 0, or faults with range checking.
        issue(1'b0, 1'b1, 32'h0, 32'h0102_0304, 4'b1111);
        issue(1'b0, 1'b1, 32'h1000, 32'hDEAD_BEEF, 4'b1111);
        issue(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
        issue(1'b1, 1'b0, 32'h1000, 32'h0, 4'h0);

        // Reset during BUSY aborts the write and clears read data.
        issue(1'b0, 1'b1, 32'h10, 32'h5A5A_5A5A, 4'b1111);
        r_v = 1'b0; w_v = 1'b1; addr = 32'h10; wdata = 32'hFFFF_FFFF; wmask = 4'b1111;
        @(posedge clk);
        @(negedge clk);
        w_v = 1'b0;
        rst_n = 1'b0;
        #1;
        check("abort_data", rdata, 32'h0, 32'hFFFF_FFFF);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        issue(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);

        // Randomized traffic over a small word window with occasional aliasing bits.
        repeat (300) begin
            kind = int'($urandom_range(0, 2));
            a = (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) a = a | (32'($urandom_range(1, 7)) << 12);
            issue(kind != 1, kind != 0, a, $urandom, 4'($urandom));
        end

        repeat (10) @(negedge clk);
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d pending, required 0", sb_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
